// File: rtl/tap_ctrl_ir.sv
// JTAG TAP controller with an instruction register and three data registers
// (BYPASS, IDCODE, USER).
//
// Parameters:
//   IR_WIDTH      - instruction register width (>= 2)
//   USER_DR_WIDTH - user data register width (>= 1)
//   IDCODE_VALUE  - 32-bit identification code, bit 0 must be 1
// Ports:
//   GCLK_Pad        in   TAP clock, all state changes on its rising edge
//   TRST_Pad        in   asynchronous active-high reset
//   TMS_Pad         in   test mode select
//   TDI_Pad         in   serial data in
//   TDO_Pad         out  serial data out (LSB of the selected shift register)
//   TDO_EN_Pad      out  high in Shift-IR / Shift-DR only
//   state_obs_Pad   out  current TAP state code
//   ir_out          out  active instruction
//   user_dr_in      in   value captured into the USER register in Capture-DR
//   user_dr_out     out  USER update register
//   update_dr_pulse out  one-cycle strobe after a USER Update-DR
module tap_ctrl_ir #(
  parameter int unsigned IR_WIDTH      = 4,
  parameter int unsigned USER_DR_WIDTH = 8,
  parameter logic [31:0] IDCODE_VALUE  = 32'h0000_0A35
) (
  input  logic                     GCLK_Pad,
  input  logic                     TRST_Pad,
  input  logic                     TMS_Pad,
  input  logic                     TDI_Pad,
  output logic                     TDO_Pad,
  output logic                     TDO_EN_Pad,
  output logic [3:0]               state_obs_Pad,
  output logic [IR_WIDTH-1:0]      ir_out,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     update_dr_pulse
);

  typedef enum logic [3:0] {
    StTlr   = 4'hF,
    StRti   = 4'hC,
    StSelDr = 4'h7,
    StCapDr = 4'h6,
    StShDr  = 4'h2,
    StEx1Dr = 4'h1,
    StPauDr = 4'h3,
    StEx2Dr = 4'h0,
    StUpdDr = 4'h5,
    StSelIr = 4'h4,
    StCapIr = 4'hE,
    StShIr  = 4'hA,
    StEx1Ir = 4'h9,
    StPauIr = 4'hB,
    StEx2Ir = 4'h8,
    StUpdIr = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IrIdcode = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IrUser   = IR_WIDTH'(2);

  tap_state_e               state_q, state_d;
  logic [IR_WIDTH-1:0]      ir_q;
  logic [IR_WIDTH-1:0]      ir_sr_q;
  logic                     bypass_q;
  logic [31:0]              idcode_sr_q;
  logic [USER_DR_WIDTH-1:0] user_sr_q;
  logic [USER_DR_WIDTH-1:0] user_dr_out_q;
  logic                     pulse_q;

  // Everything that is not IDCODE or USER (all-ones included) selects BYPASS.
  logic sel_idcode, sel_user;
  assign sel_idcode = (ir_q == IrIdcode);
  assign sel_user   = (ir_q == IrUser);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = TMS_Pad ? StTlr   : StRti;
      StRti:   state_d = TMS_Pad ? StSelDr : StRti;
      StSelDr: state_d = TMS_Pad ? StSelIr : StCapDr;
      StCapDr: state_d = TMS_Pad ? StEx1Dr : StShDr;
      StShDr:  state_d = TMS_Pad ? StEx1Dr : StShDr;
      StEx1Dr: state_d = TMS_Pad ? StUpdDr : StPauDr;
      StPauDr: state_d = TMS_Pad ? StEx2Dr : StPauDr;
      StEx2Dr: state_d = TMS_Pad ? StUpdDr : StShDr;
      StUpdDr: state_d = TMS_Pad ? StSelDr : StRti;
      StSelIr: state_d = TMS_Pad ? StTlr   : StCapIr;
      StCapIr: state_d = TMS_Pad ? StEx1Ir : StShIr;
      StShIr:  state_d = TMS_Pad ? StEx1Ir : StShIr;
      StEx1Ir: state_d = TMS_Pad ? StUpdIr : StPauIr;
      StPauIr: state_d = TMS_Pad ? StEx2Ir : StPauIr;
      StEx2Ir: state_d = TMS_Pad ? StUpdIr : StShIr;
      StUpdIr: state_d = TMS_Pad ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  // Actions are keyed on the state the controller is in at the clock edge.
  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      ir_q          <= IrIdcode;
      ir_sr_q       <= '0;
      bypass_q      <= 1'b0;
      idcode_sr_q   <= '0;
      user_sr_q     <= '0;
      user_dr_out_q <= '0;
      pulse_q       <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        StCapIr: ir_sr_q <= IR_WIDTH'(1);
        StShIr:  ir_sr_q <= {TDI_Pad, ir_sr_q[IR_WIDTH-1:1]};
        StUpdIr: ir_q    <= ir_sr_q;
        StCapDr: begin
          if (sel_idcode)    idcode_sr_q <= IDCODE_VALUE;
          else if (sel_user) user_sr_q   <= user_dr_in;
          else               bypass_q    <= 1'b0;
        end
        StShDr: begin
          if (sel_idcode) begin
            idcode_sr_q <= {TDI_Pad, idcode_sr_q[31:1]};
          end else if (sel_user) begin
            // Written as a shift so a 1-bit USER register needs no special case.
            user_sr_q <= (user_sr_q >> 1)
                       | (USER_DR_WIDTH'(TDI_Pad) << (USER_DR_WIDTH - 1));
          end else begin
            bypass_q <= TDI_Pad;
          end
        end
        StUpdDr: begin
          if (sel_user) begin
            user_dr_out_q <= user_sr_q;
            pulse_q       <= 1'b1;
          end
        end
        default: ;
      endcase
      // Arriving in (or staying in) Test-Logic-Reset selects IDCODE.
      if (state_d == StTlr) ir_q <= IrIdcode;
    end
  end

  // Registered sources only: TDI/TMS never reach TDO combinationally.
  always_comb begin
    TDO_Pad    = 1'b0;
    TDO_EN_Pad = 1'b0;
    case (state_q)
      StShIr: begin
        TDO_EN_Pad = 1'b1;
        TDO_Pad    = ir_sr_q[0];
      end
      StShDr: begin
        TDO_EN_Pad = 1'b1;
        if (sel_idcode)    TDO_Pad = idcode_sr_q[0];
        else if (sel_user) TDO_Pad = user_sr_q[0];
        else               TDO_Pad = bypass_q;
      end
      default: ;
    endcase
  end

  assign state_obs_Pad   = state_q;
  assign ir_out          = ir_q;
  assign user_dr_out     = user_dr_out_q;
  assign update_dr_pulse = pulse_q;

endmodule
